// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD multi-sector write scheduler.
package sd_sched_pkg;

  localparam int SD_SEC_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_XFER      = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6
  } sd_state_t;

  // States in which the sector writer owns the transfer and may stall.
  function automatic logic sd_in_watch(input sd_state_t s);
    return (s == ST_WAIT_BUSY) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/sd_wr_wdog.sv
// Watchdog cycle counter for the sector writer handshake; flags when the
// current watched state has lasted TIMEOUT_CYC cycles.
module sd_wr_wdog #(
  parameter int unsigned TIMEOUT_CYC = 32'd5_000_000
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  logic [31:0] cnt_reg;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // cnt_reg is 0 on the first cycle of a state, so the last allowed cycle is TIMEOUT_CYC-1.
  assign expired = run && (cnt_reg == TIMEOUT_CYC - 32'd1);

endmodule

// File: rtl/sd_wr_sched.sv
// Multi-sector SD write job scheduler: paces one sector writer from a FIFO.
// Define SD_WR_SCHED_TIMEOUT_EN to enable the sticky writer-stall watchdog.
module sd_wr_sched
  import sd_sched_pkg::*;
#(
  parameter int          SEC_WORDS   = SD_SEC_WORDS,
  parameter int          START_HOLD  = 4,
  parameter int unsigned TIMEOUT_CYC = 32'd5_000_000
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        job_start,
  input  logic [31:0] job_sec_addr,
  input  logic [15:0] job_sec_num,
  output logic        job_busy,
  output logic        job_done,
  output logic [15:0] sec_cnt,
  input  logic        sd_init_done,
  input  logic [9:0]  fifo_level,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  output logic        sd_wr_start_en,
  output logic [31:0] sd_wr_sec_addr,
  output logic [15:0] sd_wr_data,
  input  logic        sd_wr_busy,
  input  logic        sd_wr_req,
  output logic        err_timeout
);

  localparam logic [9:0]  LEVEL_MIN = 10'(SEC_WORDS);
  localparam logic [15:0] HOLD_LAST = 16'(START_HOLD - 1);

  sd_state_t   state_reg, state_next;
  logic [31:0] addr_reg;
  logic [15:0] num_reg;
  logic [15:0] sec_cnt_reg;
  logic [15:0] hold_cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        start_en_reg;
  logic        job_accept;
  logic        wdog_expired;

  // Only IDLE accepts a job, so job_start is ignored for the whole busy window.
  assign job_accept = (state_reg == ST_IDLE) && job_start;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (job_start) begin
          state_next = (job_sec_num == 16'd0) ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (sd_init_done && (fifo_level >= LEVEL_MIN)) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (wdog_expired) begin
          state_next = ST_DONE;
        end else if (sd_wr_busy) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (wdog_expired) begin
          state_next = ST_DONE;
        end else if (!sd_wr_busy) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        state_next = ((sec_cnt_reg + 16'd1) == num_reg) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      num_reg      <= '0;
      sec_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      start_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      start_en_reg <= (state_next == ST_START);
      done_reg     <= (state_reg == ST_DONE);
      hold_cnt_reg <= (state_reg == ST_START) ? hold_cnt_reg + 16'd1 : 16'd0;
      if (job_accept) begin
        addr_reg    <= job_sec_addr;
        num_reg     <= job_sec_num;
        sec_cnt_reg <= '0;
        busy_reg    <= 1'b1;
      end else if (state_reg == ST_NEXT) begin
        addr_reg    <= addr_reg + 32'd1;
        sec_cnt_reg <= sec_cnt_reg + 16'd1;
      end else if (state_reg == ST_DONE) begin
        busy_reg <= 1'b0;
      end
    end
  end

`ifdef SD_WR_SCHED_TIMEOUT_EN
  logic err_reg;

  // Any state change restarts the count, so each watched state gets a fresh budget.
  sd_wr_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_ref (clk_ref),
    .rst     (rst),
    .run     (sd_in_watch(state_reg)),
    .clr     (state_next != state_reg),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (job_accept) begin
      err_reg <= 1'b0;
    end else if (wdog_expired) begin
      err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wdog_expired       = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign job_busy       = busy_reg;
  assign job_done       = done_reg;
  assign sec_cnt        = sec_cnt_reg;
  assign sd_wr_start_en = start_en_reg;
  assign sd_wr_sec_addr = addr_reg;
  assign fifo_rd_en     = (state_reg == ST_XFER) && sd_wr_req;
  assign sd_wr_data     = fifo_rd_data;

endmodule

// File: tb/tb_sd_wr_sched.sv
// Directed bench for sd_wr_sched with a FIFO model and a sector-writer model.
`timescale 1ns/1ps
module tb_sd_wr_sched;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        job_start = 1'b0;
  logic [31:0] job_sec_addr = '0;
  logic [15:0] job_sec_num = '0;
  logic        job_busy;
  logic        job_done;
  logic [15:0] sec_cnt;
  logic        sd_init_done = 1'b1;
  logic [9:0]  fifo_level = 10'd300;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        sd_wr_start_en;
  logic [31:0] sd_wr_sec_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_busy;
  logic        sd_wr_req;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk_ref = ~clk_ref;

  sd_wr_sched #(
    .SEC_WORDS   (256),
    .START_HOLD  (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_ref        (clk_ref),
    .rst            (rst),
    .job_start      (job_start),
    .job_sec_addr   (job_sec_addr),
    .job_sec_num    (job_sec_num),
    .job_busy       (job_busy),
    .job_done       (job_done),
    .sec_cnt        (sec_cnt),
    .sd_init_done   (sd_init_done),
    .fifo_level     (fifo_level),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .sd_wr_start_en (sd_wr_start_en),
    .sd_wr_sec_addr (sd_wr_sec_addr),
    .sd_wr_data     (sd_wr_data),
    .sd_wr_busy     (sd_wr_busy),
    .sd_wr_req      (sd_wr_req),
    .err_timeout    (err_timeout)
  );

  // Writer model: busy for 600 cycles per start edge, 256 word requests inside.
  int          busy_cnt = 0;
  logic        stuck_busy = 1'b0;
  logic        start_d = 1'b0;
  int          start_edges = 0;
  int          rd_pulses = 0;
  int          done_pulses = 0;
  int          data_bad = 0;
  logic [31:0] start_addr_log [16];
  logic [15:0] fifo_word = 16'h0;

  assign sd_wr_busy = stuck_busy || (busy_cnt != 0);
  assign sd_wr_req  = !stuck_busy && (busy_cnt <= 500) && (busy_cnt >= 245);

  always @(posedge clk_ref) begin
    start_d <= sd_wr_start_en;
    if (fifo_rd_en) begin
      rd_pulses    <= rd_pulses + 1;
      fifo_word    <= fifo_word + 16'd1;
      fifo_rd_data <= fifo_word;
    end else begin
      fifo_rd_data <= 16'h0;
    end
    if (job_done) done_pulses <= done_pulses + 1;
    if (rst) begin
      busy_cnt <= 0;
    end else if (sd_wr_start_en && !start_d) begin
      busy_cnt <= 600;
      start_addr_log[start_edges % 16] <= sd_wr_sec_addr;
      start_edges <= start_edges + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk_ref) begin
    if (sd_wr_data !== fifo_rd_data) data_bad <= data_bad + 1;
  end

  task automatic pulse_job(input logic [31:0] addr, input logic [15:0] num);
    @(posedge clk_ref); #1;
    job_sec_addr = addr;
    job_sec_num  = num;
    job_start    = 1'b1;
    @(posedge clk_ref); #1;
    job_start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_ref);
      if (!job_busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: job_busy still %0b after %0d cycles, required 0", name, job_busy, max_cyc);
    end
    repeat (3) @(negedge clk_ref);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    checks++; if (job_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b want 0", job_busy); end
    checks++; if (job_done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %0b want 0", job_done); end
    checks++; if (sec_cnt !== 16'd0)       begin errors++; $display("FAIL rst_sec_cnt: got %0d want 0", sec_cnt); end
    checks++; if (sd_wr_start_en !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b want 0", sd_wr_start_en); end
    checks++; if (sd_wr_sec_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", sd_wr_sec_addr); end
    checks++; if (fifo_rd_en !== 1'b0)     begin errors++; $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en); end
    checks++; if (err_timeout !== 1'b0)    begin errors++; $display("FAIL rst_err: got %0b want 0", err_timeout); end
    @(posedge clk_ref); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_len();
    int edges0;
    edges0 = start_edges;
    pulse_job(32'h0000_0055, 16'd0);
    @(negedge clk_ref);
    checks++; if (job_busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %0b want 1", job_busy); end
    checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %0b want 0", job_done); end
    @(negedge clk_ref);
    checks++; if (job_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b want 1", job_done); end
    checks++; if (job_busy !== 1'b0) begin errors++; $display("FAIL zero_busy_drop: got %0b want 0", job_busy); end
    repeat (3) @(negedge clk_ref);
    checks++; if (start_edges !== edges0) begin errors++; $display("FAIL zero_no_start: got %0d edges want %0d", start_edges, edges0); end
    checks++; if (sec_cnt !== 16'd0) begin errors++; $display("FAIL zero_sec_cnt: got %0d want 0", sec_cnt); end
  endtask

  task automatic test_multi_sector();
    int edges0, rd0, done0;
    edges0 = start_edges; rd0 = rd_pulses; done0 = done_pulses;
    pulse_job(32'h0000_0100, 16'd3);
    @(negedge clk_ref);
    checks++; if (job_busy !== 1'b1) begin errors++; $display("FAIL multi_busy: got %0b want 1", job_busy); end
    wait_idle("multi_idle", 5000);
    checks++; if (start_edges - edges0 !== 3) begin errors++; $display("FAIL multi_edges: got %0d want 3", start_edges - edges0); end
    checks++; if (start_addr_log[edges0 % 16] !== 32'h100) begin errors++; $display("FAIL multi_addr0: got %h want 00000100", start_addr_log[edges0 % 16]); end
    checks++; if (start_addr_log[(edges0 + 1) % 16] !== 32'h101) begin errors++; $display("FAIL multi_addr1: got %h want 00000101", start_addr_log[(edges0 + 1) % 16]); end
    checks++; if (start_addr_log[(edges0 + 2) % 16] !== 32'h102) begin errors++; $display("FAIL multi_addr2: got %h want 00000102", start_addr_log[(edges0 + 2) % 16]); end
    checks++; if (rd_pulses - rd0 !== 768) begin errors++; $display("FAIL multi_rd_pulses: got %0d want 768", rd_pulses - rd0); end
    checks++; if (done_pulses - done0 !== 1) begin errors++; $display("FAIL multi_done_count: got %0d want 1", done_pulses - done0); end
    checks++; if (sec_cnt !== 16'd3) begin errors++; $display("FAIL multi_sec_cnt: got %0d want 3", sec_cnt); end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL multi_data_pass: got %0d bad cycles want 0", data_bad); end
  endtask

  task automatic test_level_gate();
    int edges0, hi_cycles;
    edges0 = start_edges;
    fifo_level = 10'd255;
    pulse_job(32'h0000_0020, 16'd1);
    repeat (20) @(negedge clk_ref);
    checks++; if (start_edges !== edges0) begin errors++; $display("FAIL level_255_start: got %0d edges want %0d", start_edges, edges0); end
    checks++; if (sd_wr_start_en !== 1'b0) begin errors++; $display("FAIL level_255_en: got %0b want 0", sd_wr_start_en); end
    @(posedge clk_ref); #1;
    fifo_level = 10'd256;
    @(negedge clk_ref);
    checks++; if (sd_wr_start_en !== 1'b0) begin errors++; $display("FAIL level_same_cycle: got %0b want 0", sd_wr_start_en); end
    @(negedge clk_ref);
    checks++; if (sd_wr_start_en !== 1'b1) begin errors++; $display("FAIL level_start: got %0b want 1", sd_wr_start_en); end
    hi_cycles = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ref);
      if (sd_wr_start_en) hi_cycles++;
    end
    checks++; if (hi_cycles !== 4) begin errors++; $display("FAIL level_hold: got %0d cycles want 4", hi_cycles); end
    wait_idle("level_idle", 2000);
    checks++; if (sec_cnt !== 16'd1) begin errors++; $display("FAIL level_sec_cnt: got %0d want 1", sec_cnt); end
    fifo_level = 10'd300;
  endtask

  task automatic test_addr_wrap();
    int edges0;
    edges0 = start_edges;
    pulse_job(32'hFFFF_FFFF, 16'd2);
    wait_idle("wrap_idle", 3000);
    checks++; if (start_addr_log[edges0 % 16] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr0: got %h want ffffffff", start_addr_log[edges0 % 16]); end
    checks++; if (start_addr_log[(edges0 + 1) % 16] !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", start_addr_log[(edges0 + 1) % 16]); end
    checks++; if (sec_cnt !== 16'd2) begin errors++; $display("FAIL wrap_sec_cnt: got %0d want 2", sec_cnt); end
  endtask

  task automatic test_busy_ignore_and_reset();
    bit ok;
    int edges0;
    pulse_job(32'h0000_0040, 16'd2);
    repeat (2) @(posedge clk_ref);
    pulse_job(32'h0000_0999, 16'd5);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_ref);
      if (fifo_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ignore_xfer: fifo_rd_en never rose in 1000 cycles, required 1"); end
    checks++; if (sd_wr_sec_addr !== 32'h40) begin errors++; $display("FAIL ignore_addr: got %h want 00000040", sd_wr_sec_addr); end
    checks++; if (sec_cnt !== 16'd0) begin errors++; $display("FAIL ignore_sec_cnt: got %0d want 0", sec_cnt); end
    @(posedge clk_ref); #1;
    rst = 1'b1;
    @(negedge clk_ref);
    checks++; if (job_busy !== 1'b0)        begin errors++; $display("FAIL abort_busy: got %0b want 0", job_busy); end
    checks++; if (job_done !== 1'b0)        begin errors++; $display("FAIL abort_done: got %0b want 0", job_done); end
    checks++; if (sec_cnt !== 16'd0)        begin errors++; $display("FAIL abort_sec_cnt: got %0d want 0", sec_cnt); end
    checks++; if (sd_wr_start_en !== 1'b0)  begin errors++; $display("FAIL abort_start: got %0b want 0", sd_wr_start_en); end
    checks++; if (sd_wr_sec_addr !== 32'd0) begin errors++; $display("FAIL abort_addr: got %h want 0", sd_wr_sec_addr); end
    checks++; if (fifo_rd_en !== 1'b0)      begin errors++; $display("FAIL abort_rd_en: got %0b want 0", fifo_rd_en); end
    checks++; if (err_timeout !== 1'b0)     begin errors++; $display("FAIL abort_err: got %0b want 0", err_timeout); end
    @(posedge clk_ref); #1;
    rst = 1'b0;
    edges0 = start_edges;
    repeat (20) @(negedge clk_ref);
    checks++; if (job_busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %0b want 0", job_busy); end
    checks++; if (start_edges !== edges0) begin errors++; $display("FAIL abort_no_restart: got %0d edges want %0d", start_edges, edges0); end
  endtask

`ifdef SD_WR_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    stuck_busy = 1'b1;
    pulse_job(32'h0000_0500, 16'd1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_ref);
      if (sd_wr_start_en) begin
        ok = 1'b1;
        break;
      end
    end
    while (ok && sd_wr_start_en) @(negedge clk_ref);
    checks++; if (!ok) begin errors++; $display("FAIL to_start: sd_wr_start_en never rose in 200 cycles, required 1"); end
    // Now in the single WAIT_BUSY cycle; XFER runs for the next 100 cycles.
    repeat (100) @(negedge clk_ref);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_early: got %0b want 0", err_timeout); end
    checks++; if (job_busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %0b want 1", job_busy); end
    @(negedge clk_ref);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err: got %0b want 1", err_timeout); end
    @(negedge clk_ref);
    checks++; if (job_done !== 1'b1) begin errors++; $display("FAIL to_done: got %0b want 1", job_done); end
    checks++; if (sec_cnt !== 16'd0) begin errors++; $display("FAIL to_sec_cnt: got %0d want 0", sec_cnt); end
    stuck_busy = 1'b0;
    repeat (5) @(negedge clk_ref);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", err_timeout); end
    pulse_job(32'h0000_0000, 16'd0);
    @(negedge clk_ref);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b want 0", err_timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_len();
    test_multi_sector();
    test_level_gate();
    test_addr_wrap();
    test_busy_ignore_and_reset();
`ifdef SD_WR_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
